// File: rtl/pck_divgen_pkg.sv
// Shared types for the multi-channel clock-enable generator: channel FSM states,
// the per-channel config record and the config sanitising rules.
package pckgen_pkg;

  // Config fields are carried at this width; CNT_W inputs are zero-extended into it.
  localparam int CFG_W = 32;

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} ch_state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
    logic [CFG_W-1:0] phase;
  } ch_cfg_t;

  // DIV of 0 runs as 1; a phase past the period end lands on its last cycle.
  function automatic ch_cfg_t cfg_sanitize(ch_cfg_t c);
    ch_cfg_t r;
    r = c;
    if (r.div == '0) r.div = CFG_W'(1);
    if (r.phase >= r.div) r.phase = r.div - CFG_W'(1);
    return r;
  endfunction

  function automatic ch_cfg_t cfg_reset(int unsigned div_init);
    ch_cfg_t r;
    r.div   = CFG_W'(div_init);
    r.high  = CFG_W'(div_init / 2);
    r.phase = '0;
    return r;
  endfunction

endpackage

// File: rtl/pck_divgen_if.sv
// Control/config inputs and strobe outputs of pck_divgen; the generator is the slave.
interface pck_divgen_if #(
  parameter int NCH   = 2,
  parameter int CNT_W = 16,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]   en;
  logic             sync;
  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_high;
  logic [CNT_W-1:0] cfg_phase;
  logic [NCH-1:0]   pck_en;
  logic [NCH-1:0]   pck_out;
  logic             locked;

  modport master (
    output en, sync, cfg_we, cfg_ch, cfg_div, cfg_high, cfg_phase,
    input  pck_en, pck_out, locked
  );

  modport slave (
    input  en, sync, cfg_we, cfg_ch, cfg_div, cfg_high, cfg_phase,
    output pck_en, pck_out, locked
  );
endinterface

// File: rtl/pck_divgen_ch.sv
// One divider channel: shadow/active config, phase and period counters,
// IDLE/ALIGN/RUN FSM and the per-channel lock flag.
module pck_divgen_ch
  import pckgen_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 4
) (
  input  logic    sysclk,
  input  logic    rst_n,
  input  logic    en,
  input  logic    sync,
  input  logic    we,
  input  ch_cfg_t wcfg,
  output logic    pck_en,
  output logic    pck_out,
  output logic    act,
  output logic    lock
);

  localparam ch_cfg_t RST_CFG = cfg_sanitize(cfg_reset(DIV_INIT));

  ch_state_t        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, pc, pc_n;
  ch_cfg_t          shd, shd_n;
  logic [CFG_W-1:0] adiv, adiv_n, ahigh, ahigh_n;
  logic             pend, pend_n, lock_q, lock_n;
  logic             pen_q, pen_n, pout_q, pout_n;
  logic             wrap;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pc_n    = pc;
    shd_n   = shd;
    adiv_n  = adiv;
    ahigh_n = ahigh;
    pend_n  = pend;
    lock_n  = lock_q;
    wrap    = (state == RUN) && (CFG_W'(cnt) == adiv - CFG_W'(1));

    if (!en) begin
      state_n = IDLE;
      cnt_n   = '0;
      pc_n    = '0;
    end else if (sync || state == IDLE) begin
      state_n = ALIGN;
      adiv_n  = shd.div;
      ahigh_n = shd.high;
      pc_n    = CNT_W'(shd.phase);
      cnt_n   = '0;
      pend_n  = 1'b0;
    end else if (state == ALIGN) begin
      if (pc == '0) begin
        state_n = RUN;
        cnt_n   = '0;
      end else begin
        pc_n = pc - CNT_W'(1);
      end
    end else if (wrap) begin
      // Period boundary: take a pending config, otherwise this wrap proves the config settled.
      cnt_n = '0;
      if (pend) begin
        adiv_n  = shd.div;
        ahigh_n = shd.high;
        pend_n  = 1'b0;
      end else begin
        lock_n = 1'b1;
      end
    end else begin
      cnt_n = cnt + CNT_W'(1);
    end

    // A write landing on a load edge stays pending for the next boundary.
    if (we) begin
      shd_n  = cfg_sanitize(wcfg);
      pend_n = 1'b1;
      lock_n = 1'b0;
    end
    if (state_n != RUN) lock_n = 1'b0;

    pen_n  = (state == RUN) && (cnt == '0);
    pout_n = (state == RUN) && (CFG_W'(cnt) < ahigh);
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      pc     <= '0;
      shd    <= RST_CFG;
      adiv   <= RST_CFG.div;
      ahigh  <= RST_CFG.high;
      pend   <= 1'b0;
      lock_q <= 1'b0;
      pen_q  <= 1'b0;
      pout_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      pc     <= pc_n;
      shd    <= shd_n;
      adiv   <= adiv_n;
      ahigh  <= ahigh_n;
      pend   <= pend_n;
      lock_q <= lock_n;
      pen_q  <= pen_n;
      pout_q <= pout_n;
    end
  end

  assign pck_en  = pen_q;
  assign pck_out = pout_q;
  assign act     = (state != IDLE);
  assign lock    = lock_q;

endmodule

// File: rtl/pck_divgen.sv
// Multi-channel clock-enable generator: NCH divider channels, config write
// decode and the registered LOCKED reduction.
module pck_divgen
  import pckgen_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = 4
) (
  input logic          sysclk,
  input logic          rst_n,
  pck_divgen_if.slave  bus
);

  ch_cfg_t        wcfg;
  logic [NCH-1:0] we_dec, act, lock, pen_v, pout_v;
  logic           locked_q;

  always_comb begin
    wcfg       = '0;
    wcfg.div   = CFG_W'(bus.cfg_div);
    wcfg.high  = CFG_W'(bus.cfg_high);
    wcfg.phase = CFG_W'(bus.cfg_phase);
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range channel numbers match no lane and are dropped.
    assign we_dec[i] = bus.cfg_we && (int'(bus.cfg_ch) == i);

    pck_divgen_ch #(.CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) u_ch (
      .sysclk  (sysclk),
      .rst_n   (rst_n),
      .en      (bus.en[i]),
      .sync    (bus.sync),
      .we      (we_dec[i]),
      .wcfg    (wcfg),
      .pck_en  (pen_v[i]),
      .pck_out (pout_v[i]),
      .act     (act[i]),
      .lock    (lock[i])
    );
  end

  always_ff @(posedge sysclk) begin
    if (!rst_n) locked_q <= 1'b0;
    else        locked_q <= (|act) && (&(lock | ~act));
  end

  assign bus.pck_en  = pen_v;
  assign bus.pck_out = pout_v;
  assign bus.locked  = locked_q;

endmodule
